// File: rtl/alu24_divider.sv
// rtl/alu24_divider.sv - multi-cycle restoring 24-bit signed/unsigned divider
module alu24_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] dvnd_mag;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        dvnd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvsr_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        // Partial remainder stays below 2*divisor, so bit WIDTH is a reliable sign.
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
        q_fix    = neg_quo_q ? -quo_q : quo_q;
        r_fix    = neg_rem_q ? -rem_q : rem_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d     = '0;
                    cnt_d     = '0;
                    dvsr_d    = dvsr_mag;
                    neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed && dividend[WIDTH-1];
                    ovf_d     = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                && (divisor == {WIDTH{1'b1}});
                    dz_d      = (divisor == '0);
                    busy_d    = 1'b1;
                    if (divisor == '0) begin
                        // Raw dividend is parked in the quotient register for the remainder.
                        quo_d   = dividend;
                        state_d = FINISH;
                    end else begin
                        quo_d   = dvnd_mag;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                cnt_d      = '0;
                state_d    = IDLE;
                div_zero_d = dz_q;
                overflow_d = ovf_q;
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                    zero_d      = 1'b0;
                end else begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                    zero_d      = (q_fix == '0);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu24_divider.sv
// tb/tb_alu24_divider.sv - self-checking bench for alu24_divider
module tb_alu24_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [23:0] dividend = '0;
    logic [23:0] divisor = '0;
    logic        busy, done, div_zero, overflow, zero;
    logic [23:0] quotient, remainder;

    alu24_divider #(.WIDTH(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] q;
        logic [23:0] r;
        logic        dz;
        logic        ov;
        logic        z;
    } res_t;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];
    res_t last = '{24'h0, 24'h0, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic s, input logic [23:0] a, input logic [23:0] b);
        res_t   res;
        longint na, nb, q, r;
        res.dz = 1'b0;
        res.ov = 1'b0;
        if (b == 24'h0) begin
            res.q  = 24'hFFFFFF;
            res.r  = a;
            res.dz = 1'b1;
        end else begin
            if (s) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
                res.ov = (na == -64'sd8388608) && (nb == -64'sd1);
            end else begin
                na = longint'({40'h0, a});
                nb = longint'({40'h0, b});
            end
            q = na / nb;
            r = na % nb;
            res.q = q[23:0];
            res.r = r[23:0];
        end
        res.z = (res.q == 24'h0);
        return res;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {31'h0, done}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", {8'h0, quotient}, {8'h0, e.q});
                    check("remainder", {8'h0, remainder}, {8'h0, e.r});
                    check("div_zero", {31'h0, div_zero}, {31'h0, e.dz});
                    check("overflow", {31'h0, overflow}, {31'h0, e.ov});
                    check("zero", {31'h0, zero}, {31'h0, e.z});
                    last = e;
                end
            end else begin
                check("hold_quotient", {8'h0, quotient}, {8'h0, last.q});
                check("hold_remainder", {8'h0, remainder}, {8'h0, last.r});
                check("hold_flags", {29'h0, div_zero, overflow, zero},
                      {29'h0, last.dz, last.ov, last.z});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_quotient"}, {8'h0, quotient}, 32'h0);
        check({tag, "_remainder"}, {8'h0, remainder}, 32'h0);
        check({tag, "_flags"}, {29'h0, div_zero, overflow, zero}, 32'h0);
    endtask

    // Called #1 after an edge where busy is expected; counts busy samples until done.
    task automatic wait_done(input string name, input int exp_busy);
        int nb = 0;
        int n = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_timeout"}, {31'h0, done}, 32'h1);
        check({name, "_busy_cycles"}, nb, exp_busy);
        check({name, "_busy_in_done"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic do_op(input string name, input logic s, input logic [23:0] a,
                         input logic [23:0] b, input int exp_busy);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        exp_q.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        start     = 1'b0;
        is_signed = 1'($urandom_range(1));
        dividend  = 24'($urandom);
        divisor   = 24'($urandom);
        wait_done(name, exp_busy);
    endtask

    res_t pin;

    initial begin
        pin = model(1'b0, 24'd100, 24'd7);
        check("pin_u100_7_q", {8'h0, pin.q}, 32'd14);
        check("pin_u100_7_r", {8'h0, pin.r}, 32'd2);
        pin = model(1'b1, 24'hFFFF9C, 24'd7);
        check("pin_sm100_7_q", {8'h0, pin.q}, 32'hFFFFF2);
        check("pin_sm100_7_r", {8'h0, pin.r}, 32'hFFFFFE);
        pin = model(1'b1, 24'd100, 24'hFFFFF9);
        check("pin_s100_m7_q", {8'h0, pin.q}, 32'hFFFFF2);
        check("pin_s100_m7_r", {8'h0, pin.r}, 32'd2);
        pin = model(1'b1, 24'h800000, 24'hFFFFFF);
        check("pin_ovf_q", {8'h0, pin.q}, 32'h800000);
        check("pin_ovf_flag", {31'h0, pin.ov}, 32'h1);
        pin = model(1'b0, 24'h123456, 24'h0);
        check("pin_dz_r", {8'h0, pin.r}, 32'h123456);
        pin = model(1'b0, 24'd5, 24'd9);
        check("pin_zero_flag", {31'h0, pin.z}, 32'h1);

        #3 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("u100_7", 1'b0, 24'd100, 24'd7, 25);
        do_op("sm100_7", 1'b1, 24'hFFFF9C, 24'd7, 25);
        do_op("s100_m7", 1'b1, 24'd100, 24'hFFFFF9, 25);
        do_op("dz_u", 1'b0, 24'h123456, 24'h0, 1);
        do_op("dz_s", 1'b1, 24'h800000, 24'h0, 1);
        do_op("s_ovf", 1'b1, 24'h800000, 24'hFFFFFF, 25);
        do_op("u_max_1", 1'b0, 24'hFFFFFF, 24'h000001, 25);
        do_op("u5_9", 1'b0, 24'd5, 24'd9, 25);
        do_op("sm7_m2", 1'b1, 24'hFFFFF9, 24'hFFFFFE, 25);
        do_op("u_max_max", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 25);
        do_op("u_800000_3", 1'b0, 24'h800000, 24'd3, 25);
        do_op("s_800000_u", 1'b0, 24'h800000, 24'hFFFFFF, 25);

        // Noise while busy, then Start held across Done for a back-to-back op.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 24'd1000;
        divisor   = 24'd33;
        exp_q.push_back(model(1'b0, 24'd1000, 24'd33));
        @(posedge clk);
        #1;
        repeat (20) begin
            start     = 1'($urandom_range(1));
            is_signed = 1'($urandom_range(1));
            dividend  = 24'($urandom);
            divisor   = 24'($urandom);
            @(posedge clk);
            #1;
        end
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 24'hFFFFF9;
        divisor   = 24'd2;
        exp_q.push_back(model(1'b1, 24'hFFFFF9, 24'd2));
        wait_done("b2b_first", 5);
        @(posedge clk);
        #1;
        check("b2b_no_idle", {31'h0, busy}, 32'h1);
        start = 1'b0;
        wait_done("b2b_second", 25);

        // Reset during iteration 10 aborts with no Done.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 24'h654321;
        divisor   = 24'h000123;
        exp_q.push_back(model(1'b0, 24'h654321, 24'h000123));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        last = '{24'h0, 24'h0, 1'b0, 1'b0, 1'b0};
        #1 check_all_zero("abort");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1 check("abort_no_done_q", {8'h0, quotient}, 32'h0);
        do_op("after_reset", 1'b0, 24'd1000, 24'd10, 25);
        check("after_reset_q", {8'h0, quotient}, 32'd100);
        check("after_reset_r", {8'h0, remainder}, 32'd0);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
